fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller in front of program_counter. It generates the PC's en and branch controls
//  and runs a single-outstanding request/response handshake to instruction memory.
//  It presents each fetched word to decode with a valid/ready handshake, and applies redirect, halt and
//  timeout handling. It sits between program_counter, the imem port and the IF/ID boundary.
// PARAMETERS
//  XLEN        32   address/data width
//  TIMEOUT     255  max cycles in WAIT before fetch_error (8-bit counter, 1..255)
// PORTS
//  clk                   in   1     system clock
//  rst_n                 in   1     asynchronous active-low reset
//  pc                    in   XLEN  current PC from program_counter
//  pc_en                 out  1     PC advance/load enable
//  pc_branch_enable      out  1     PC load of branch target this cycle
//  pc_branch_is_relative out  1     target = pc + pc_branch_addr when 1
//  pc_branch_addr        out  XLEN  target or offset, passed through from redirect_addr
//  imem_req_valid        out  1     fetch request valid
//  imem_req_ready        in   1     imem accepts request
//  imem_req_addr         out  XLEN  fetch address (= pc)
//  imem_resp_valid       in   1     response word valid (1-cycle pulse)
//  imem_resp_data        in   XLEN  instruction word
//  redirect_valid        in   1     1-cycle redirect pulse from EX/trap logic
//  redirect_is_relative  in   1     redirect offset mode
//  redirect_addr         in   XLEN  redirect target or offset
//  halt_req              in   1     level: stop fetching after the current transaction
//  if_valid              out  1     fetched instruction valid to decode
//  if_ready              in   1     decode accepts instruction
//  if_instr              out  XLEN  fetched instruction
//  if_pc                 out  XLEN  address of if_instr
//  fetch_error           out  1     sticky: imem timeout; cleared only by reset
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT, OUT, HALTED. Reset -> IDLE, all outputs 0, kill=0, timer=0.
//  - IDLE: 1 cycle; -> HALTED if halt_req, else -> REQ.
//  - REQ: imem_req_valid=1, imem_req_addr=pc. On req_ready: pc_en=1 (PC += 4), latch pc into addr_q, timer=0,
//    go to WAIT. The request address is the pre-increment pc.
//  - WAIT: timer++. On resp_valid: if kill, drop the word, clear kill, -> REQ (or HALTED if halt_req).
//    Otherwise register if_instr=data and if_pc=addr_q, -> OUT. if_valid is high the cycle after resp_valid.
//  - Timeout: timer reaches TIMEOUT with no resp -> fetch_error=1, -> HALTED. Only reset exits this halt.
//  - OUT: if_valid=1 and held stable until if_ready. On if_valid&&if_ready -> REQ, or HALTED if halt_req.
//  - Redirect (any state): pc_en=1, pc_branch_enable=1, and mode/addr pass through combinationally the
//    same cycle. Redirect takes priority over the REQ sequential advance (the request is withdrawn that cycle).
//    Relative redirects are offsets from the PC register value in that cycle.
//    * REQ: imem_req_valid=0 that cycle; stay in REQ.
//    * WAIT: set kill; the in-flight response is discarded.
//    * OUT: drop if_valid next cycle (instruction flushed, even if if_ready is also high); -> REQ.
//    * HALTED/IDLE: PC is loaded; state is unchanged.
//  - HALTED: no requests; pc_en=0 except on redirect. Deasserting halt_req -> REQ, unless fetch_error is set.
//  - halt_req never aborts a transaction; it is sampled only at WAIT/OUT exit and in IDLE.
//  - At most one imem request is outstanding. A resp_valid outside WAIT is ignored.
//  - Async reset mid-transaction: immediate return to IDLE and a kill of all state. The PC is reset
//    separately by program_counter.
// STRUCTURE
//  - Shared package (cpu_pkg): state encoding localparams (IDLE=0..HALTED=4), XLEN, INSTR_NOP.
//  - Single module: FSM and timer inline; no sub-module.
// TESTING
//  1 Reset then release, imem ready=1, 1-cycle response latency: imem_req_addr 0x0,0x4,0x8...; if_pc matches
//    if_instr; PC steps +4 per fetch.
//  2 Absolute redirect to 0x1000 while in WAIT: the old response is dropped (no if_valid); next
//    imem_req_addr=0x1000.
//  3 Relative redirect +0x100 with pc=0x1008 in OUT: if_valid falls next cycle; next request at 0x1108.
//  4 if_ready=0 for 5 cycles in OUT: if_valid, if_instr and if_pc are stable and no new request is issued.
//  5 halt_req raised in WAIT: the response is delivered, then HALTED with no requests. Drop halt_req ->
//    fetching resumes at the next pc.
//  6 imem never responds: after 255 WAIT cycles fetch_error=1 and HALTED. rst_n low clears it.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM state encoding and a NOP word.
// Imported by the fetch sequencer and its interface.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_OUT    = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  // Where a finished transaction goes: park if halt is requested, else fetch again.
  function automatic fetch_state_e after_transaction(input logic halt_req);
    return halt_req ? ST_HALTED : ST_REQ;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: PC control, imem request/response, redirect/halt and the IF/ID handshake.
// master = fetch sequencer, slave = surrounding PC, imem and pipeline logic.
interface fetch_sequencer_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] pc;
  logic            pc_en;
  logic            pc_branch_enable;
  logic            pc_branch_is_relative;
  logic [XLEN-1:0] pc_branch_addr;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  logic            redirect_valid;
  logic            redirect_is_relative;
  logic [XLEN-1:0] redirect_addr;
  logic            halt_req;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            fetch_error;

  modport master (
    input  pc,
    output pc_en, pc_branch_enable, pc_branch_is_relative, pc_branch_addr,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_is_relative, redirect_addr, halt_req,
    output if_valid, if_instr, if_pc, fetch_error,
    input  if_ready
  );

  modport slave (
    output pc,
    input  pc_en, pc_branch_enable, pc_branch_is_relative, pc_branch_addr,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_is_relative, redirect_addr, halt_req,
    input  if_valid, if_instr, if_pc, fetch_error,
    output if_ready
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives program_counter, runs one outstanding imem transaction
// at a time and hands fetched words to decode, with redirect, halt and timeout handling.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  fetch_state_e    state;
  logic            kill;
  logic [7:0]      timer;
  logic [XLEN-1:0] addr_q;
  logic            req_fire;

  // The request must be withdrawn in the very cycle a redirect arrives, so it cannot be registered.
  assign bus.imem_req_valid = (state == ST_REQ) && !bus.redirect_valid;
  assign bus.imem_req_addr  = bus.pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.pc_en                 = bus.redirect_valid || req_fire;
  assign bus.pc_branch_enable      = bus.redirect_valid;
  assign bus.pc_branch_is_relative = bus.redirect_valid && bus.redirect_is_relative;
  assign bus.pc_branch_addr        = bus.redirect_valid ? bus.redirect_addr : '0;

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      kill            <= 1'b0;
      timer           <= '0;
      addr_q          <= '0;
      bus.if_valid    <= 1'b0;
      bus.if_instr    <= '0;
      bus.if_pc       <= '0;
      bus.fetch_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.redirect_valid) state <= after_transaction(bus.halt_req);
        end

        ST_REQ: begin
          if (req_fire) begin
            addr_q <= bus.pc;
            timer  <= '0;
            state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.imem_resp_valid) begin
            // A redirect in the response cycle makes that word stale as well.
            if (kill || bus.redirect_valid) begin
              kill  <= 1'b0;
              state <= after_transaction(bus.halt_req);
            end else begin
              bus.if_valid <= 1'b1;
              bus.if_instr <= bus.imem_resp_data;
              bus.if_pc    <= addr_q;
              state        <= ST_OUT;
            end
          end else if (timer == TIMER_LAST) begin
            bus.fetch_error <= 1'b1;
            kill            <= 1'b0;
            state           <= ST_HALTED;
          end else begin
            timer <= timer + 8'd1;
            if (bus.redirect_valid) kill <= 1'b1;
          end
        end

        ST_OUT: begin
          if (bus.redirect_valid) begin
            bus.if_valid <= 1'b0;
            state        <= ST_REQ;
          end else if (bus.if_ready) begin
            bus.if_valid <= 1'b0;
            state        <= after_transaction(bus.halt_req);
          end
        end

        ST_HALTED: begin
          if (!bus.redirect_valid && !bus.halt_req && !bus.fetch_error) state <= ST_REQ;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run scored
// against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Environment: program counter, imem responder and stimulus knobs.
  logic [31:0] pc_model;
  int          lat = 1;
  bit          never = 1'b0;
  int          ready_pct = 100;
  int          if_ready_pct = 100;
  int          countdown = 0;
  logic [31:0] resp_addr;

  // Transaction-level expectation of the fetch stream.
  bit          inflight, killed;
  logic [31:0] inflight_addr;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          n_acc = 0, n_deliv = 0, n_ifv = 0;

  task automatic cycle();
    bit          accepted;
    bit          s_pc_en, s_br, s_rel;
    logic [31:0] s_baddr;
    @(negedge clk);
    accepted = bus.imem_req_valid && bus.imem_req_ready;
    check("pc_en", 32'(bus.pc_en), 32'(accepted || bus.redirect_valid));
    if (bus.imem_req_valid) check("single_outstanding", 32'(inflight), 0);
    if (bus.if_valid) begin
      n_ifv++;
      check("if_valid_expected", 32'(exp_q.size() > 0), 1);
    end
    if (bus.if_valid && bus.if_ready && !bus.redirect_valid && exp_q.size() > 0) begin
      check("if_pc", bus.if_pc, exp_q[0]);
      check("if_instr", bus.if_instr, imem_word(exp_q[0]));
      void'(exp_q.pop_front());
      n_deliv++;
    end
    if (bus.redirect_valid) begin
      check("redirect_req_withdrawn", 32'(bus.imem_req_valid), 0);
      check("redirect_branch_en", 32'(bus.pc_branch_enable), 1);
      check("redirect_rel", 32'(bus.pc_branch_is_relative), 32'(bus.redirect_is_relative));
      check("redirect_addr", bus.pc_branch_addr, bus.redirect_addr);
      if (inflight) killed = 1'b1;
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (bus.imem_resp_valid && inflight) begin
      if (!killed) exp_q.push_back(inflight_addr);
      inflight = 1'b0;
    end
    if (accepted) begin
      check("req_addr", bus.imem_req_addr, pc_model);
      inflight      = 1'b1;
      killed        = 1'b0;
      inflight_addr = bus.imem_req_addr;
      resp_addr     = bus.imem_req_addr;
      acc_q.push_back(bus.imem_req_addr);
      n_acc++;
      countdown = never ? 0 : lat;
    end
    s_pc_en = bus.pc_en;
    s_br    = bus.pc_branch_enable;
    s_rel   = bus.pc_branch_is_relative;
    s_baddr = bus.pc_branch_addr;

    @(posedge clk);
    #1;
    if (s_pc_en) pc_model = s_br ? (s_rel ? pc_model + s_baddr : s_baddr) : pc_model + 32'd4;
    bus.pc = pc_model;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = imem_word(resp_addr);
      end
    end
    bus.imem_req_ready       = ($urandom_range(99) < ready_pct);
    bus.if_ready             = ($urandom_range(99) < if_ready_pct);
    bus.redirect_valid       = 1'b0;
    bus.redirect_is_relative = 1'b0;
    bus.redirect_addr        = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pc = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_is_relative = 1'b0;
    bus.redirect_addr = '0;
    bus.halt_req = 1'b0;
    bus.if_ready = 1'b0;
    pc_model = '0;
    countdown = 0;
    inflight = 1'b0;
    killed = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_valid", 32'(bus.if_valid), 0);
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_pc_en", 32'(bus.pc_en), 0);
    check("rst_fetch_error", 32'(bus.fetch_error), 0);
    check("rst_if_instr", bus.if_instr, 0);
    check("rst_if_pc", bus.if_pc, 0);
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
  endtask

  task automatic wait_acc(input int target, input int max);
    int i = 0;
    while (n_acc < target && i < max) begin cycle(); i++; end
    check("wait_accept_in_time", 32'(n_acc >= target), 1);
  endtask

  task automatic wait_deliv(input int target, input int max);
    int i = 0;
    while (n_deliv < target && i < max) begin cycle(); i++; end
    check("wait_delivery_in_time", 32'(n_deliv >= target), 1);
  endtask

  task automatic wait_ifv(input int max);
    int i = 0;
    while (!bus.if_valid && i < max) begin cycle(); i++; end
    check("wait_if_valid_in_time", 32'(bus.if_valid), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc, hold_instr, p;
    int          a0, d0, f0, v0;

    // 1: straight-line fetch from reset.
    do_reset();
    wait_acc(3, 30);
    check("t1_addr0", acc_q[0], 32'h0);
    check("t1_addr1", acc_q[1], 32'h4);
    check("t1_addr2", acc_q[2], 32'h8);
    wait_deliv(3, 30);
    check("t1_pc_after_3", pc_model, 32'hC);
    check("t1_next_req_addr", bus.imem_req_addr, 32'hC);

    // 2: absolute redirect while waiting for a response.
    lat = 3;
    wait_acc(n_acc + 1, 20);
    v0 = n_ifv;
    bus.redirect_valid = 1'b1;
    bus.redirect_is_relative = 1'b0;
    bus.redirect_addr = 32'h1000;
    cycle();
    lat = 1;
    wait_acc(n_acc + 1, 20);
    check("t2_req_after_redirect", acc_q[$], 32'h1000);
    check("t2_dropped_no_if_valid", 32'(n_ifv - v0), 0);

    // 4: decode stalls for 5 cycles holding the word at 0x1004.
    wait_deliv(n_deliv + 1, 20);
    if_ready_pct = 0;
    bus.if_ready = 1'b0;
    wait_acc(n_acc + 1, 20);
    wait_ifv(20);
    check("t4_if_pc", bus.if_pc, 32'h1004);
    check("t4_pc", pc_model, 32'h1008);
    hold_pc = bus.if_pc;
    hold_instr = bus.if_instr;
    a0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_hold_valid", 32'(bus.if_valid), 1);
      check("t4_hold_pc", bus.if_pc, hold_pc);
      check("t4_hold_instr", bus.if_instr, hold_instr);
      check("t4_no_req", 32'(bus.imem_req_valid), 0);
    end
    check("t4_no_accept", 32'(n_acc), 32'(a0));

    // 3: relative redirect +0x100 while in OUT.
    bus.redirect_valid = 1'b1;
    bus.redirect_is_relative = 1'b1;
    bus.redirect_addr = 32'h100;
    cycle();
    check("t3_if_valid_dropped", 32'(bus.if_valid), 0);
    if_ready_pct = 100;
    wait_acc(n_acc + 1, 20);
    check("t3_req_addr", acc_q[$], 32'h1108);

    // 5: halt raised during WAIT.
    lat = 3;
    wait_acc(n_acc + 1, 20);
    bus.halt_req = 1'b1;
    d0 = n_deliv;
    wait_deliv(d0 + 1, 20);
    a0 = n_acc;
    p = pc_model;
    repeat (10) cycle();
    check("t5_halted_no_accept", 32'(n_acc), 32'(a0));
    check("t5_halted_no_req", 32'(bus.imem_req_valid), 0);
    check("t5_pc_frozen", pc_model, p);
    bus.halt_req = 1'b0;
    lat = 1;
    wait_acc(a0 + 1, 20);
    check("t5_resume_addr", acc_q[$], p);

    // 6: imem never answers.
    never = 1'b1;
    wait_acc(n_acc + 1, 20);
    repeat (254) cycle();
    check("t6_no_error_at_254", 32'(bus.fetch_error), 0);
    cycle();
    check("t6_error_at_255", 32'(bus.fetch_error), 1);
    f0 = n_acc;
    repeat (10) cycle();
    check("t6_halted_no_accept", 32'(n_acc), 32'(f0));
    check("t6_sticky", 32'(bus.fetch_error), 1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_clears_error", 32'(bus.fetch_error), 0);
    never = 1'b0;

    // Randomized traffic: backpressure, latency and redirects.
    do_reset();
    ready_pct = 70;
    if_ready_pct = 70;
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(15) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_is_relative = 1'($urandom_range(1));
        if (bus.redirect_is_relative) begin
          p = {22'b0, 8'($urandom_range(255)), 2'b00};
          if ($urandom_range(1) == 1) p = -p;
        end else begin
          p = {16'b0, 14'($urandom_range(16383)), 2'b00};
        end
        bus.redirect_addr = p;
      end
      cycle();
    end
    check("random_progress", 32'((n_deliv - d0) > 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
